plab5_mcore_debug_responder: RTL and testbench
==============================================

Name: plab5_mcore_debug_responder

Overview:
- Memory-side executor for debug commands issued by the mcore debug interface.
- Accepts a one-cycle start pulse carrying inst, src_addr, dest_addr and domain.
- Performs the memory operation through a simple val/rdy port and returns a one-cycle ack with read_data and db_resp_domain.
- Enforces a secure address window: low-domain requests touching the window are denied without any memory access.

Parameters:
- p_addr_nbits, 32, address width
- p_data_nbits, 32, data width
- p_sec_base, 32'h0000_F000, first address of the secure window (inclusive)
- p_sec_limit, 32'h0000_FFFF, last address of the secure window (inclusive)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- inst  in  1  0 = copy mem[src_addr] to mem[dest_addr]; 1 = read mem[src_addr]
- src_addr  in  p_addr_nbits  source address
- dest_addr  in  p_addr_nbits  destination address; ignored when inst=1
- domain  in  1  requester security level; 0 = low, 1 = high
- ack  out  1  one-cycle completion pulse
- read_data  out  p_data_nbits  data returned with ack
- db_resp_domain  out  1  domain of the completed command
- denied  out  1  valid with ack; 1 = command rejected by the window check
- mem_req_val  out  1  memory request valid
- mem_req_rdy  in  1  memory request ready
- mem_req_type  out  1  0 = read, 1 = write
- mem_req_addr  out  p_addr_nbits  memory address
- mem_req_data  out  p_data_nbits  write data
- mem_resp_val  in  1  memory response valid; always accepted, no rdy
- mem_resp_data  in  p_data_nbits  read response data

Behaviour:
- Reset values: state IDLE; ack=0, denied=0, mem_req_val=0, read_data=0, db_resp_domain=0. Latched command registers are cleared.
- IDLE, start=1: latch inst, src_addr, dest_addr and domain.
  - Check order is fixed. Deny if domain==0 and src lies in [p_sec_base, p_sec_limit].
  - Also deny if domain==0, inst==0 and dest lies in the window.
  - Denied -> ACK. Allowed and inst=1 -> RD_REQ. Allowed and inst=0 -> CP_RD_REQ.
- IDLE, start=0: remain in IDLE. mem_resp_val is ignored; this discards stale responses after a reset.
- start in any state other than IDLE is ignored and causes no queuing.
- RD_REQ / CP_RD_REQ:
  - Drive mem_req_val=1, type=0, addr=src.
  - Advance to RD_WAIT / CP_RD_WAIT on the cycle val&&rdy is true.
  - Hold all request fields stable while rdy=0.
- RD_WAIT: on mem_resp_val, capture mem_resp_data into read_data and go to ACK.
- CP_RD_WAIT: on mem_resp_val, capture data into an internal copy register and into read_data, then go to CP_WR_REQ.
- CP_WR_REQ:
  - Drive mem_req_val=1, type=1, addr=dest, data=copy register.
  - On val&&rdy, go to CP_WR_WAIT.
- CP_WR_WAIT: on mem_resp_val (write ack; data ignored), go to ACK.
- ACK:
  - ack=1 for exactly one cycle. db_resp_domain = latched domain; denied as computed.
  - On deny, read_data=0.
  - Next state is IDLE. A start arriving in this cycle is ignored.
- read_data, db_resp_domain and denied hold their values after ack until the next ack.
- Latency with a zero-wait memory (rdy=1, response on the cycle after the handshake):
  - read: 4 cycles from start to ack
  - copy: 6 cycles
  - denied: 2 cycles
- Address compare is unsigned over the full p_addr_nbits. Window boundaries are inclusive.
- mem_req_val is 0 in IDLE, all WAIT states and ACK. A response in a REQ state cannot occur; it is ignored.
- Asynchronous reset mid-operation aborts immediately.
  - Any in-flight memory response is dropped in IDLE.
  - No ack is produced for the aborted command.

Test Plan:
1. Read: mem[0x100]=0xDEADBEEF; start, inst=1, src=0x100, domain=0, rdy=1 -> ack 4 cycles later, read_data=0xDEADBEEF, db_resp_domain=0, denied=0.
2. Copy: mem[0x200]=0x12345678; inst=0, src=0x200, dest=0x300, domain=1 -> one read at 0x200, then one write of 0x12345678 at 0x300; ack 6 cycles after start; mem[0x300]=0x12345678.
3. Denied read: domain=0, inst=1, src=0xF000 -> no mem_req_val; ack 2 cycles later with denied=1, read_data=0. Repeat with domain=1 -> allowed. src=0xEFFC with domain=0 -> allowed.
4. Denied copy: domain=0, src=0x100, dest=0xFFFF -> no memory traffic; denied=1.
5. Backpressure: mem_req_rdy=0 for 5 cycles during a read -> addr/type held stable and a single handshake; ack at 9 cycles. A second start while busy -> ignored, exactly one ack.
6. Reset mid-copy: assert reset asynchronously in CP_WR_WAIT -> ack=0 and mem_req_val=0 immediately. A late mem_resp_val after reset -> no ack. A new read then completes normally.

Source files
------------

// File: rtl/plab5_mcore_debug_responder.sv
// Debug command executor: performs read and copy commands through a val/rdy memory
// port. Low-domain commands that touch the secure window are denied with no memory access.
module plab5_mcore_debug_responder #(
    parameter int unsigned               p_addr_nbits = 32,
    parameter int unsigned               p_data_nbits = 32,
    parameter logic [p_addr_nbits-1:0]   p_sec_base   = 32'h0000_F000,
    parameter logic [p_addr_nbits-1:0]   p_sec_limit  = 32'h0000_FFFF
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    start,
    input  logic                    inst,
    input  logic [p_addr_nbits-1:0] src_addr,
    input  logic [p_addr_nbits-1:0] dest_addr,
    input  logic                    domain,

    output logic                    ack,
    output logic [p_data_nbits-1:0] read_data,
    output logic                    db_resp_domain,
    output logic                    denied,

    output logic                    mem_req_val,
    input  logic                    mem_req_rdy,
    output logic                    mem_req_type,
    output logic [p_addr_nbits-1:0] mem_req_addr,
    output logic [p_data_nbits-1:0] mem_req_data,

    input  logic                    mem_resp_val,
    input  logic [p_data_nbits-1:0] mem_resp_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        CP_RD_REQ,
        CP_RD_WAIT,
        CP_WR_REQ,
        CP_WR_WAIT,
        ACK
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [p_addr_nbits-1:0] src_reg;
    logic [p_addr_nbits-1:0] dest_reg;
    logic                    domain_reg;
    logic                    deny_reg;
    logic [p_data_nbits-1:0] copy_reg;

    logic                    src_in_win;
    logic                    dest_in_win;
    logic                    cmd_deny;

    // Window check on the incoming command; the destination only matters for copies.
    assign src_in_win  = (src_addr  >= p_sec_base) && (src_addr  <= p_sec_limit);
    assign dest_in_win = (dest_addr >= p_sec_base) && (dest_addr <= p_sec_limit);
    assign cmd_deny    = !domain && (src_in_win || (!inst && dest_in_win));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_reg    <= '0;
            dest_reg   <= '0;
            domain_reg <= 1'b0;
            deny_reg   <= 1'b0;
        end else if (state == IDLE && start) begin
            src_reg    <= src_addr;
            dest_reg   <= dest_addr;
            domain_reg <= domain;
            deny_reg   <= cmd_deny;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            copy_reg <= '0;
        end else if ((state == RD_WAIT || state == CP_RD_WAIT) && mem_resp_val) begin
            copy_reg <= mem_resp_data;
        end
    end

    // Results are published together with the ack pulse and then held until the next ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack            <= 1'b0;
            read_data      <= '0;
            db_resp_domain <= 1'b0;
            denied         <= 1'b0;
        end else begin
            ack <= (state == ACK);
            if (state == ACK) begin
                read_data      <= deny_reg ? '0 : copy_reg;
                db_resp_domain <= domain_reg;
                denied         <= deny_reg;
            end
        end
    end

    always_comb begin
        state_next   = state;
        mem_req_val  = 1'b0;
        mem_req_type = 1'b0;
        mem_req_addr = src_reg;
        mem_req_data = copy_reg;

        case (state)
            IDLE: begin
                if (start) begin
                    if (cmd_deny) begin
                        state_next = ACK;
                    end else if (inst) begin
                        state_next = RD_REQ;
                    end else begin
                        state_next = CP_RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                mem_req_val = 1'b1;
                if (mem_req_rdy) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_resp_val) begin
                    state_next = ACK;
                end
            end
            CP_RD_REQ: begin
                mem_req_val = 1'b1;
                if (mem_req_rdy) begin
                    state_next = CP_RD_WAIT;
                end
            end
            CP_RD_WAIT: begin
                if (mem_resp_val) begin
                    state_next = CP_WR_REQ;
                end
            end
            CP_WR_REQ: begin
                mem_req_val  = 1'b1;
                mem_req_type = 1'b1;
                mem_req_addr = dest_reg;
                if (mem_req_rdy) begin
                    state_next = CP_WR_WAIT;
                end
            end
            CP_WR_WAIT: begin
                if (mem_resp_val) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_plab5_mcore_debug_responder.sv
// Scoreboard bench for plab5_mcore_debug_responder: directed and random debug commands
// against a model memory, with expected acks and memory requests queued at issue time.
module tb_plab5_mcore_debug_responder;

    localparam logic [31:0] SEC_BASE  = 32'h0000_F000;
    localparam logic [31:0] SEC_LIMIT = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        inst;
    logic [31:0] src_addr;
    logic [31:0] dest_addr;
    logic        domain;
    logic        ack;
    logic [31:0] read_data;
    logic        db_resp_domain;
    logic        denied;
    logic        mem_req_val;
    logic        mem_req_rdy;
    logic        mem_req_type;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_resp_val;
    logic [31:0] mem_resp_data;

    plab5_mcore_debug_responder dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .inst           (inst),
        .src_addr       (src_addr),
        .dest_addr      (dest_addr),
        .domain         (domain),
        .ack            (ack),
        .read_data      (read_data),
        .db_resp_domain (db_resp_domain),
        .denied         (denied),
        .mem_req_val    (mem_req_val),
        .mem_req_rdy    (mem_req_rdy),
        .mem_req_type   (mem_req_type),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_val   (mem_resp_val),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        dom;
        logic        den;
        int          start_cyc;
        int          exp_lat;
    } ack_t;

    typedef struct {
        logic        typ;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    ack_t        ack_q[$];
    req_t        req_q[$];
    logic [31:0] mem [logic [31:0]];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_acks = 0;
    bit          random_mode = 1'b0;
    int          stall_left = 0;
    int          resp_timer = 0;
    bit          inject_resp = 1'b0;
    logic [31:0] resp_data_pend = '0;
    bit          prev_stall = 1'b0;
    logic        prev_type;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        return (a >= SEC_BASE) && (a <= SEC_LIMIT);
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(6))
            0:       return SEC_BASE - 32'd1;
            1:       return SEC_BASE;
            2:       return SEC_LIMIT;
            3:       return SEC_LIMIT + 32'd1;
            4:       return $urandom_range(32'h0000_EFFF);
            5:       return SEC_BASE + $urandom_range(32'h0FFF);
            default: return $urandom | 32'h8000_0000;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Issue one command; the reference outcome is derived from the window rule and the model memory.
    task automatic apply_stimulus(input logic i, input logic [31:0] s, input logic [31:0] d,
                                  input logic dm, input int lat);
        ack_t        e;
        req_t        r;
        bit          dn;
        logic [31:0] v;
        @(negedge clk);
        dn = !dm && (in_window(s) || (!i && in_window(d)));
        v  = mem_rd(s);
        e.data = dn ? 32'h0 : v;
        e.dom = dm;
        e.den = dn;
        e.start_cyc = cyc;
        e.exp_lat = lat;
        ack_q.push_back(e);
        if (!dn) begin
            r.typ = 1'b0; r.addr = s; r.data = 32'h0;
            req_q.push_back(r);
            if (!i) begin
                r.typ = 1'b1; r.addr = d; r.data = v;
                req_q.push_back(r);
            end
        end
        start = 1'b1; inst = i; src_addr = s; dest_addr = d; domain = dm;
        @(negedge clk);
        start = 1'b0;
        inst = 1'($urandom);
        src_addr = $urandom;
        dest_addr = $urandom;
        domain = 1'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((ack_q.size() != 0 || req_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (ack_q.size() != 0 || req_q.size() != 0) begin
            n_checks++;
            $display("[TB] FAIL timeout: %0d acks and %0d requests still outstanding, expected 0",
                     ack_q.size(), req_q.size());
            ack_q.delete();
            req_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Model memory: handshakes are checked against the queued requests, responses follow later.
    initial begin
        req_t r;
        mem_req_rdy = 1'b0;
        mem_resp_val = 1'b0;
        mem_resp_data = '0;
        forever begin
            @(negedge clk);
            mem_resp_val = 1'b0;
            if (inject_resp) begin
                mem_resp_val = 1'b1;
                mem_resp_data = 32'hBAD0_BAD0;
            end
            if (resp_timer > 0) begin
                resp_timer--;
                if (resp_timer == 0) begin
                    mem_resp_val = 1'b1;
                    mem_resp_data = resp_data_pend;
                end
            end
            if (reset) begin
                mem_req_rdy = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_output("stall_val", mem_req_val, 1'b1);
                    check_output("stall_type", mem_req_type, prev_type);
                    check_output("stall_addr", mem_req_addr, prev_addr);
                    if (prev_type) check_output("stall_data", mem_req_data, prev_data);
                end
                if (mem_req_val && stall_left > 0) begin
                    mem_req_rdy = 1'b0;
                    stall_left--;
                end else if (random_mode) begin
                    mem_req_rdy = ($urandom_range(3) != 0);
                end else begin
                    mem_req_rdy = 1'b1;
                end
                prev_stall = mem_req_val && !mem_req_rdy;
                prev_type = mem_req_type;
                prev_addr = mem_req_addr;
                prev_data = mem_req_data;
                if (mem_req_val && mem_req_rdy) begin
                    if (req_q.size() == 0) begin
                        n_checks++;
                        $display("[TB] FAIL unexpected_req: got request addr 0x%0h type %0d, expected none",
                                 mem_req_addr, mem_req_type);
                    end else begin
                        r = req_q.pop_front();
                        check_output("req_type", mem_req_type, r.typ);
                        check_output("req_addr", mem_req_addr, r.addr);
                        if (r.typ) check_output("req_data", mem_req_data, r.data);
                    end
                    if (mem_req_type) begin
                        mem[mem_req_addr] = mem_req_data;
                        resp_data_pend = 32'h0;
                    end else begin
                        resp_data_pend = mem_rd(mem_req_addr);
                    end
                    resp_timer = 1 + (random_mode ? int'($urandom_range(2)) : 0);
                end
            end
        end
    end

    initial begin
        ack_t e;
        forever begin
            @(negedge clk);
            if (ack === 1'b1) begin
                n_acks++;
                if (ack_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_ack: got ack=1 at cycle %0d, expected no ack", cyc);
                end else begin
                    e = ack_q.pop_front();
                    check_output("read_data", read_data, e.data);
                    check_output("db_resp_domain", db_resp_domain, e.dom);
                    check_output("denied", denied, e.den);
                    if (e.exp_lat >= 0) check_output("ack_latency", cyc - e.start_cyc, e.exp_lat);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acks_before;
        int n;
        reset = 1'b1;
        start = 1'b0;
        inst = 1'b0;
        src_addr = '0;
        dest_addr = '0;
        domain = 1'b0;
        #3;
        check_output("rst_ack", ack, 1'b0);
        check_output("rst_denied", denied, 1'b0);
        check_output("rst_req_val", mem_req_val, 1'b0);
        check_output("rst_read_data", read_data, 32'h0);
        check_output("rst_domain", db_resp_domain, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] read");
        mem[32'h100] = 32'hDEAD_BEEF;
        apply_stimulus(1'b1, 32'h100, 32'h0, 1'b0, 4);
        wait_done(50);

        $display("[TB] copy");
        mem[32'h200] = 32'h1234_5678;
        apply_stimulus(1'b0, 32'h200, 32'h300, 1'b1, 6);
        wait_done(50);
        check_output("copy_mem", mem.exists(32'h300) ? mem[32'h300] : 32'h0, 32'h1234_5678);

        $display("[TB] window reads");
        apply_stimulus(1'b1, 32'hF000, 32'h0, 1'b0, 2);
        wait_done(50);
        apply_stimulus(1'b1, 32'hF000, 32'h0, 1'b1, 4);
        wait_done(50);
        apply_stimulus(1'b1, 32'hEFFC, 32'h0, 1'b0, 4);
        wait_done(50);
        apply_stimulus(1'b1, 32'hFFFF, 32'h0, 1'b0, 2);
        wait_done(50);
        apply_stimulus(1'b1, 32'h1_0000, 32'h0, 1'b0, 4);
        wait_done(50);

        $display("[TB] denied copy");
        apply_stimulus(1'b0, 32'h100, 32'hFFFF, 1'b0, 2);
        wait_done(50);

        $display("[TB] backpressure and busy start");
        acks_before = n_acks;
        stall_left = 5;
        apply_stimulus(1'b1, 32'h100, 32'h0, 1'b1, 9);
        start = 1'b1; inst = 1'b0; src_addr = 32'h700; dest_addr = 32'h800; domain = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(50);
        repeat (4) @(negedge clk);
        check_output("busy_start_acks", n_acks - acks_before, 1);

        $display("[TB] reset mid copy");
        apply_stimulus(1'b0, 32'h500, 32'h600, 1'b1, -1);
        n = 0;
        while (req_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("reach_wr_wait", req_q.size(), 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_output("abort_ack", ack, 1'b0);
        check_output("abort_req_val", mem_req_val, 1'b0);
        check_output("abort_read_data", read_data, 32'h0);
        ack_q.delete();
        req_q.delete();
        #1;
        reset = 1'b0;
        acks_before = n_acks;
        repeat (6) @(negedge clk);
        inject_resp = 1'b1;
        @(negedge clk);
        inject_resp = 1'b0;
        repeat (4) @(negedge clk);
        check_output("late_resp_acks", n_acks - acks_before, 0);
        apply_stimulus(1'b1, 32'h100, 32'h0, 1'b0, 4);
        wait_done(50);

        $display("[TB] random commands");
        random_mode = 1'b1;
        for (int k = 0; k < 60; k++) begin
            apply_stimulus(1'($urandom), pick_addr(), pick_addr(), 1'($urandom), -1);
            wait_done(200);
        end
        random_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
